// File: rtl/grf_write_scheduler_pkg.sv
// grf_write_scheduler_pkg: shared widths and the queued MDU result record
package grf_sched_pkg;
  localparam int REG_AW = 5;
  localparam int DATA_W = 32;
  typedef struct packed {
    logic [REG_AW-1:0] a3;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] pc;
  } md_entry_t;
  function automatic logic [31:0] reg_bit(input logic [REG_AW-1:0] a);
    return 32'd1 << a;
  endfunction
endpackage

// File: rtl/grf_write_scheduler_if.sv
// grf_write_scheduler_if: WB, MDU, decode and GRF write-port signals
interface grf_write_scheduler_if;
  import grf_sched_pkg::*;
  logic              wb_valid;
  logic [REG_AW-1:0] wb_a3;
  logic [DATA_W-1:0] wb_wd;
  logic [DATA_W-1:0] wb_pc;
  logic              wb_stall;
  logic              md_valid;
  logic [REG_AW-1:0] md_a3;
  logic [DATA_W-1:0] md_wd;
  logic [DATA_W-1:0] md_pc;
  logic              md_ready;
  logic              md_issue;
  logic [REG_AW-1:0] md_issue_a3;
  logic [REG_AW-1:0] dec_a1;
  logic [REG_AW-1:0] dec_a2;
  logic [REG_AW-1:0] dec_a3;
  logic              dec_stall;
  logic [REG_AW-1:0] grf_a3;
  logic [DATA_W-1:0] grf_wd;
  logic [DATA_W-1:0] grf_pc;
  modport master (
    output wb_valid, wb_a3, wb_wd, wb_pc, md_valid, md_a3, md_wd, md_pc,
           md_issue, md_issue_a3, dec_a1, dec_a2, dec_a3,
    input  wb_stall, md_ready, dec_stall, grf_a3, grf_wd, grf_pc
  );
  modport slave (
    input  wb_valid, wb_a3, wb_wd, wb_pc, md_valid, md_a3, md_wd, md_pc,
           md_issue, md_issue_a3, dec_a1, dec_a2, dec_a3,
    output wb_stall, md_ready, dec_stall, grf_a3, grf_wd, grf_pc
  );
endinterface

// File: rtl/grf_write_scheduler_fifo.sv
// sched_fifo: circular buffer of MDU results that lost the GRF port
module sched_fifo
  import grf_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  logic      pop,
  input  md_entry_t din,
  output md_entry_t head,
  output logic      full,
  output logic      empty
);
  localparam int PW = $clog2(DEPTH);
  md_entry_t mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  // count never exceeds DEPTH (a power of two), so its MSB alone means full
  assign head  = mem[rd_ptr];
  assign full  = count[PW];
  assign empty = count == '0;
endmodule

// File: rtl/grf_write_scheduler.sv
// grf_write_scheduler: arbitrates the GRF write port between WB and MDU, tracks pending MDU writes
module grf_write_scheduler
  import grf_sched_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input logic clk,
  input logic reset,
  grf_write_scheduler_if.slave bus
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_cnt;
  logic [31:0] pending, pending_nx;
  md_entry_t head, md_in, wb_in, grant;
  logic full, empty, push, pop, bypass, starve, wb_w;
  assign md_in = '{a3: bus.md_a3, wd: bus.md_wd, pc: bus.md_pc};
  assign wb_in = '{a3: bus.wb_a3, wd: bus.wb_wd, pc: bus.wb_pc};
  // reset gating keeps the port idle while reset is held, whatever the inputs do
  always_comb begin
    wb_w          = !reset && bus.wb_valid && bus.wb_a3 != '0;
    starve        = !empty && starve_cnt == SW'(STARVE_MAX);
    pop           = !empty && (starve || !wb_w);
    bypass        = !reset && !starve && !wb_w && empty && bus.md_valid;
    bus.md_ready  = !full || pop;
    push          = bus.md_valid && bus.md_ready && !bypass;
    bus.wb_stall  = starve && bus.wb_valid;
    grant         = pop ? head : wb_w ? wb_in : bypass ? md_in : '0;
    bus.grf_a3    = grant.a3;
    bus.grf_wd    = grant.wd;
    bus.grf_pc    = grant.pc;
    pending_nx    = (pending & ~((pop || bypass) ? reg_bit(grant.a3) : 32'd0))
                  | (bus.md_issue ? reg_bit(bus.md_issue_a3) : 32'd0);
    pending_nx[0] = 1'b0;
    bus.dec_stall = pending[bus.dec_a1] || pending[bus.dec_a2] || pending[bus.dec_a3]
                  || (bus.md_issue && pending[bus.md_issue_a3]);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      starve_cnt <= '0;
      pending    <= '0;
    end else begin
      starve_cnt <= (empty || pop) ? '0
                  : starve_cnt == SW'(STARVE_MAX) ? starve_cnt : starve_cnt + 1'b1;
      pending    <= pending_nx;
    end
  sched_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .pop(pop),
    .din(md_in), .head(head), .full(full), .empty(empty)
  );
endmodule

// File: tb/tb_grf_write_scheduler.sv
// tb_grf_write_scheduler: directed scenarios plus random traffic against a queue-based model
module tb_grf_write_scheduler;
  import grf_sched_pkg::*;
  localparam int DEPTH = 4;
  localparam int SMAX  = 3;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;
  grf_write_scheduler_if bus ();
  grf_write_scheduler #(.DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  md_entry_t mq[$];
  int msc;
  logic [31:0] mpend;
  logic [4:0] e_a3;
  logic [31:0] e_wd, e_pc;
  logic e_stall, e_ready, e_dec, e_pop, e_byp;

  task automatic model_eval();
    bit wbw = bus.wb_valid && bus.wb_a3 != 0;
    bit st = mq.size() > 0 && msc == SMAX;
    md_entry_t g = '0;
    e_pop = mq.size() > 0 && (st || !wbw);
    e_byp = !st && !wbw && mq.size() == 0 && bus.md_valid;
    if (e_pop) g = mq[0];
    else if (wbw) g = '{bus.wb_a3, bus.wb_wd, bus.wb_pc};
    else if (e_byp) g = '{bus.md_a3, bus.md_wd, bus.md_pc};
    e_a3 = g.a3;
    e_wd = g.wd;
    e_pc = g.pc;
    e_stall = st && bus.wb_valid;
    e_ready = mq.size() < DEPTH || e_pop;
    e_dec = (bus.dec_a1 != 0 && mpend[bus.dec_a1]) || (bus.dec_a2 != 0 && mpend[bus.dec_a2])
         || (bus.dec_a3 != 0 && mpend[bus.dec_a3]) || (bus.md_issue && mpend[bus.md_issue_a3]);
  endtask

  task automatic model_commit();
    bit was_empty = mq.size() == 0;
    bit acc = bus.md_valid && e_ready && !e_byp;
    if (e_pop || e_byp) mpend[e_a3] = 1'b0;
    if (e_pop) mq.delete(0);
    if (acc) mq.push_back('{bus.md_a3, bus.md_wd, bus.md_pc});
    msc = (was_empty || e_pop) ? 0 : (msc < SMAX ? msc + 1 : SMAX);
    if (bus.md_issue) mpend[bus.md_issue_a3] = 1'b1;
    mpend[0] = 1'b0;
  endtask

  task automatic model_reset();
    mq.delete();
    msc = 0;
    mpend = '0;
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic drive_idle();
    bus.wb_valid = 0; bus.wb_a3 = 0; bus.wb_wd = 0; bus.wb_pc = 0;
    bus.md_valid = 0; bus.md_a3 = 0; bus.md_wd = 0; bus.md_pc = 0;
    bus.md_issue = 0; bus.md_issue_a3 = 0;
    bus.dec_a1 = 0; bus.dec_a2 = 0; bus.dec_a3 = 0;
  endtask

  task automatic test_reset();
    drive_idle();
    model_reset();
    #3;
    checks++; if ({bus.grf_a3, bus.grf_wd, bus.grf_pc} !== 69'd0) begin errors++; $display("FAIL reset_grf: got a3=%0d wd=%h pc=%h want 0", bus.grf_a3, bus.grf_wd, bus.grf_pc); end
    checks++; if (bus.wb_stall !== 1'b0) begin errors++; $display("FAIL reset_wb_stall: got %b want 0", bus.wb_stall); end
    checks++; if (bus.md_ready !== 1'b1) begin errors++; $display("FAIL reset_md_ready: got %b want 1", bus.md_ready); end
    checks++; if (bus.dec_stall !== 1'b0) begin errors++; $display("FAIL reset_dec_stall: got %b want 0", bus.dec_stall); end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_bypass();
    drive_idle();
    bus.md_issue = 1; bus.md_issue_a3 = 8;
    tick();
    drive_idle();
    bus.dec_a1 = 8; bus.md_valid = 1; bus.md_a3 = 8; bus.md_wd = 32'h1234; bus.md_pc = 32'h400;
    #2;
    checks++; if (bus.grf_a3 !== 5'd8 || bus.grf_wd !== 32'h1234 || bus.grf_pc !== 32'h400) begin errors++; $display("FAIL bypass_grf: got a3=%0d wd=%h pc=%h want 8/1234/400", bus.grf_a3, bus.grf_wd, bus.grf_pc); end
    checks++; if (bus.dec_stall !== 1'b1) begin errors++; $display("FAIL bypass_pending_before: got %b want 1", bus.dec_stall); end
    tick();
    drive_idle();
    bus.dec_a1 = 8;
    #2;
    checks++; if (bus.dec_stall !== 1'b0) begin errors++; $display("FAIL bypass_pending_cleared: got %b want 0", bus.dec_stall); end
    checks++; if (bus.grf_a3 !== 5'd0) begin errors++; $display("FAIL bypass_idle: got %0d want 0", bus.grf_a3); end
    tick();
  endtask

  task automatic test_wb_priority();
    drive_idle();
    bus.wb_valid = 1; bus.wb_a3 = 5; bus.wb_wd = 32'hAAAA; bus.wb_pc = 32'h100;
    bus.md_valid = 1; bus.md_a3 = 9; bus.md_wd = 32'h9999; bus.md_pc = 32'h200;
    #2;
    checks++; if (bus.grf_a3 !== 5'd5 || bus.grf_wd !== 32'hAAAA) begin errors++; $display("FAIL prio_wb: got a3=%0d wd=%h want 5/aaaa", bus.grf_a3, bus.grf_wd); end
    checks++; if (bus.md_ready !== 1'b1) begin errors++; $display("FAIL prio_md_ready: got %b want 1", bus.md_ready); end
    tick();
    drive_idle();
    #2;
    checks++; if (bus.grf_a3 !== 5'd9 || bus.grf_wd !== 32'h9999 || bus.grf_pc !== 32'h200) begin errors++; $display("FAIL prio_fifo: got a3=%0d wd=%h pc=%h want 9/9999/200", bus.grf_a3, bus.grf_wd, bus.grf_pc); end
    tick();
    // wb_valid with a3=0 is not a write, so a lone MDU result bypasses
    bus.wb_valid = 1; bus.wb_a3 = 0; bus.md_valid = 1; bus.md_a3 = 4; bus.md_wd = 32'h44;
    #2;
    checks++; if (bus.grf_a3 !== 5'd4 || bus.grf_wd !== 32'h44) begin errors++; $display("FAIL prio_wb_zero: got a3=%0d wd=%h want 4/44", bus.grf_a3, bus.grf_wd); end
    tick();
  endtask

  task automatic test_starve();
    logic [31:0] cur = 32'h100;
    logic stalled;
    for (int k = 0; k < 6; k++) begin
      drive_idle();
      bus.wb_valid = 1; bus.wb_a3 = 7; bus.wb_wd = cur; bus.wb_pc = cur + 32'h1000;
      bus.md_valid = (k == 0); bus.md_a3 = 10; bus.md_wd = 32'hBEEF; bus.md_pc = 32'h5000;
      #2;
      if (k == 4) begin
        checks++; if (bus.grf_a3 !== 5'd10 || bus.grf_wd !== 32'hBEEF) begin errors++; $display("FAIL starve_pop: got a3=%0d wd=%h want 10/beef", bus.grf_a3, bus.grf_wd); end
        checks++; if (bus.wb_stall !== 1'b1) begin errors++; $display("FAIL starve_stall: got %b want 1", bus.wb_stall); end
      end else begin
        checks++; if (bus.grf_a3 !== 5'd7 || bus.grf_wd !== cur) begin errors++; $display("FAIL starve_wb_k%0d: got a3=%0d wd=%h want 7/%h", k, bus.grf_a3, bus.grf_wd, cur); end
        checks++; if (bus.wb_stall !== 1'b0) begin errors++; $display("FAIL starve_nostall_k%0d: got %b want 0", k, bus.wb_stall); end
      end
      stalled = bus.wb_stall;
      tick();
      if (!stalled) cur = cur + 1;
    end
    drive_idle();
  endtask

  task automatic test_full();
    int exp_a3 [9] = '{3, 3, 3, 3, 16, 3, 3, 3, 17};
    bit exp_rdy [9] = '{1, 1, 1, 1, 1, 0, 0, 0, 1};
    int id = 16;
    logic rdy;
    for (int c = 0; c < 9; c++) begin
      drive_idle();
      bus.wb_valid = 1; bus.wb_a3 = 3; bus.wb_wd = 32'h77; bus.wb_pc = 32'h700;
      bus.md_valid = 1; bus.md_a3 = 5'(id); bus.md_wd = 32'h9000 + id; bus.md_pc = 32'(id);
      #2;
      checks++; if (bus.grf_a3 !== 5'(exp_a3[c])) begin errors++; $display("FAIL full_grf_c%0d: got %0d want %0d", c, bus.grf_a3, exp_a3[c]); end
      checks++; if (bus.md_ready !== exp_rdy[c]) begin errors++; $display("FAIL full_ready_c%0d: got %b want %b", c, bus.md_ready, exp_rdy[c]); end
      rdy = bus.md_ready;
      tick();
      if (rdy) id++;
    end
    drive_idle();
    for (int d = 18; d < 22; d++) begin
      #2;
      checks++; if (bus.grf_a3 !== 5'(d) || bus.grf_wd !== 32'h9000 + d) begin errors++; $display("FAIL full_drain_%0d: got a3=%0d wd=%h want %0d", d, bus.grf_a3, bus.grf_wd, d); end
      tick();
    end
    #2;
    checks++; if (bus.grf_a3 !== 5'd0) begin errors++; $display("FAIL full_drained: got %0d want 0", bus.grf_a3); end
    tick();
  endtask

  task automatic test_scoreboard();
    drive_idle();
    bus.md_issue = 1; bus.md_issue_a3 = 12;
    #2;
    checks++; if (bus.dec_stall !== 1'b0) begin errors++; $display("FAIL sb_first_issue: got %b want 0", bus.dec_stall); end
    tick();
    drive_idle(); bus.dec_a1 = 12;
    #2;
    checks++; if (bus.dec_stall !== 1'b1) begin errors++; $display("FAIL sb_raw: got %b want 1", bus.dec_stall); end
    tick();
    drive_idle(); bus.md_issue = 1; bus.md_issue_a3 = 12;
    #2;
    checks++; if (bus.dec_stall !== 1'b1) begin errors++; $display("FAIL sb_reissue: got %b want 1", bus.dec_stall); end
    drive_idle(); bus.md_issue = 1; bus.md_issue_a3 = 0;
    #1;
    checks++; if (bus.dec_stall !== 1'b0) begin errors++; $display("FAIL sb_r0: got %b want 0", bus.dec_stall); end
    tick();
    drive_idle(); bus.dec_a3 = 12; bus.md_valid = 1; bus.md_a3 = 12; bus.md_wd = 32'h55;
    #2;
    checks++; if (bus.grf_a3 !== 5'd12 || bus.dec_stall !== 1'b1) begin errors++; $display("FAIL sb_commit: got a3=%0d stall=%b want 12/1", bus.grf_a3, bus.dec_stall); end
    tick();
    drive_idle(); bus.dec_a3 = 12;
    #2;
    checks++; if (bus.dec_stall !== 1'b0) begin errors++; $display("FAIL sb_cleared: got %b want 0", bus.dec_stall); end
    bus.md_issue = 1; bus.md_issue_a3 = 13;
    tick();
    drive_idle(); bus.md_issue = 1; bus.md_issue_a3 = 13; bus.md_valid = 1; bus.md_a3 = 13;
    tick();
    drive_idle(); bus.dec_a2 = 13;
    #2;
    checks++; if (bus.dec_stall !== 1'b1) begin errors++; $display("FAIL sb_set_wins: got %b want 1", bus.dec_stall); end
    bus.md_valid = 1; bus.md_a3 = 13;
    tick();
    drive_idle(); bus.dec_a2 = 13;
    #2;
    checks++; if (bus.dec_stall !== 1'b0) begin errors++; $display("FAIL sb_set_wins_clear: got %b want 0", bus.dec_stall); end
    tick();
  endtask

  task automatic test_reset_mid();
    drive_idle(); bus.md_issue = 1; bus.md_issue_a3 = 9;
    tick();
    drive_idle();
    bus.wb_valid = 1; bus.wb_a3 = 5; bus.md_valid = 1; bus.md_a3 = 9; bus.md_wd = 32'hAA;
    tick();
    drive_idle(); bus.dec_a1 = 9;
    #2;
    checks++; if (bus.dec_stall !== 1'b1 || bus.grf_a3 !== 5'd9) begin errors++; $display("FAIL rstmid_before: got stall=%b a3=%0d want 1/9", bus.dec_stall, bus.grf_a3); end
    reset = 1'b1;
    #1;
    checks++; if (bus.grf_a3 !== 5'd0 || bus.dec_stall !== 1'b0 || bus.md_ready !== 1'b1) begin errors++; $display("FAIL rstmid_async: got a3=%0d stall=%b ready=%b want 0/0/1", bus.grf_a3, bus.dec_stall, bus.md_ready); end
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    #2;
    checks++; if (bus.grf_a3 !== 5'd0 || bus.dec_stall !== 1'b0) begin errors++; $display("FAIL rstmid_after: got a3=%0d stall=%b want 0/0", bus.grf_a3, bus.dec_stall); end
    tick();
  endtask

  task automatic test_random();
    bit hold = 0;
    for (int n = 0; n < 400; n++) begin
      bus.wb_valid = 1'($urandom_range(0, 1));
      bus.wb_a3 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      bus.wb_wd = $urandom; bus.wb_pc = $urandom;
      if (!hold) begin
        bus.md_valid = ($urandom_range(0, 2) == 0);
        bus.md_a3 = 5'($urandom_range(1, 15));
        bus.md_wd = $urandom; bus.md_pc = $urandom;
      end
      bus.md_issue = ($urandom_range(0, 3) == 0);
      bus.md_issue_a3 = 5'($urandom_range(0, 15));
      bus.dec_a1 = 5'($urandom_range(0, 15));
      bus.dec_a2 = 5'($urandom_range(0, 15));
      bus.dec_a3 = 5'($urandom_range(0, 15));
      #2;
      model_eval();
      checks++; if ({bus.grf_a3, bus.grf_wd, bus.grf_pc} !== {e_a3, e_wd, e_pc}) begin errors++; $display("FAIL rnd_grf_%0d: got %0d/%h/%h want %0d/%h/%h", n, bus.grf_a3, bus.grf_wd, bus.grf_pc, e_a3, e_wd, e_pc); end
      checks++; if (bus.wb_stall !== e_stall) begin errors++; $display("FAIL rnd_wb_stall_%0d: got %b want %b", n, bus.wb_stall, e_stall); end
      checks++; if (bus.md_ready !== e_ready) begin errors++; $display("FAIL rnd_md_ready_%0d: got %b want %b", n, bus.md_ready, e_ready); end
      checks++; if (bus.dec_stall !== e_dec) begin errors++; $display("FAIL rnd_dec_stall_%0d: got %b want %b", n, bus.dec_stall, e_dec); end
      hold = bus.md_valid && !e_ready;
      tick();
    end
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_wb_priority();
    test_starve();
    test_full();
    test_scoreboard();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
